// File: rtl/sprite_renderer.sv
`default_nettype none
// ============================================================================
//  Module      : sprite_renderer
//  Description : Bouncing square sprite overlaid on a bordered background.
//                The sprite moves STEP pixels per frame and is steered by
//                pushbuttons. btn_c toggles between RUN and PAUSE. Colour
//                and syncs leave the block one clock after the timing inputs.
//  Ports       : clk25                  - pixel clock, sole clock
//                rst_n                  - synchronous active-low reset
//                hc, vc                 - horizontal / vertical counters
//                vidon                  - visible-area flag
//                hsync_in, vsync_in     - active-low syncs from timing stage
//                btn_up/down/left/right - asynchronous steering buttons
//                btn_c                  - asynchronous run/pause toggle
//                red, green, blue       - registered pixel colour
//                hsync_out, vsync_out   - syncs aligned with the colour
//                frame_tick             - one-cycle pulse per frame update
//  Revision    : 1.0 - initial release
// ============================================================================
module sprite_renderer #(
    parameter int HBP  = 144,
    parameter int VBP  = 31,
    parameter int HPIX = 640,
    parameter int VPIX = 480,
    parameter int SPR  = 32,
    parameter int STEP = 2
) (
    input  logic       clk25,
    input  logic       rst_n,
    input  logic [9:0] hc,
    input  logic [9:0] vc,
    input  logic       vidon,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_c,
    output logic [3:0] red,
    output logic [3:0] green,
    output logic [3:0] blue,
    output logic       hsync_out,
    output logic       vsync_out,
    output logic       frame_tick
);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_PAUSE = 1'b1
    } state_t;

    localparam logic [10:0] c_x_max  = 11'(HPIX - SPR);
    localparam logic [10:0] c_y_max  = 11'(VPIX - SPR);
    localparam logic [10:0] c_step   = 11'(STEP);
    localparam logic [10:0] c_spr    = 11'(SPR);
    localparam logic [9:0]  c_hbp    = 10'(HBP);
    localparam logic [9:0]  c_vbp    = 10'(VBP);
    localparam logic [9:0]  c_hlim   = 10'(HPIX - 4);
    localparam logic [9:0]  c_vlim   = 10'(VPIX - 4);
    localparam logic [9:0]  c_x_init = 10'((HPIX - SPR) / 2);
    localparam logic [9:0]  c_y_init = 10'((VPIX - SPR) / 2);

    // Button bit order inside the synchronizer: {c, right, left, down, up}
    logic [4:0]  r_btn_s1;
    logic [4:0]  r_btn_s2;
    logic        r_btn_c_prev;
    logic        r_vs_prev;
    logic [9:0]  r_x;
    logic [9:0]  r_y;
    logic        r_dx;
    logic        r_dy;
    state_t      r_state;

    logic        w_btn_c_rise;
    logic [10:0] w_x_upd;
    logic [10:0] w_y_upd;
    logic [9:0]  w_px;
    logic [9:0]  w_py;
    logic        w_in_spr;
    logic        w_border;
    logic [11:0] w_rgb;

    // One axis of motion. Returns {new_dir, new_pos}. The direction is first
    // steered by the buttons (both or neither pressed keeps it), then the
    // position steps and bounces off either edge of [0, limit].
    function automatic logic [10:0] f_axis(
        input logic [9:0]  pos,
        input logic        dir,
        input logic        btn_neg,
        input logic        btn_pos,
        input logic [10:0] limit
    );
        logic        nd;
        logic [10:0] p;
        nd = dir;
        p  = {1'b0, pos};
        if (btn_neg && !btn_pos) begin
            nd = 1'b0;
        end else if (btn_pos && !btn_neg) begin
            nd = 1'b1;
        end
        if (nd) begin
            if (p + c_step > limit) begin
                return {1'b0, limit[9:0]};
            end
            return {1'b1, pos + c_step[9:0]};
        end
        if (p < c_step) begin
            return {1'b1, 10'd0};
        end
        return {1'b0, pos - c_step[9:0]};
    endfunction

    always_comb begin
        w_btn_c_rise = r_btn_s2[4] & ~r_btn_c_prev;
        w_x_upd      = f_axis(r_x, r_dx, r_btn_s2[2], r_btn_s2[3], c_x_max);
        w_y_upd      = f_axis(r_y, r_dy, r_btn_s2[0], r_btn_s2[1], c_y_max);

        // Wrapping 10-bit subtraction; off-screen counters land far outside
        // the visible range and are masked by vidon anyway.
        w_px     = hc - c_hbp;
        w_py     = vc - c_vbp;
        w_in_spr = ({1'b0, w_px} >= {1'b0, r_x}) && ({1'b0, w_px} < {1'b0, r_x} + c_spr) &&
                   ({1'b0, w_py} >= {1'b0, r_y}) && ({1'b0, w_py} < {1'b0, r_y} + c_spr);
        w_border = (w_px < 10'd4) || (w_px >= c_hlim) || (w_py < 10'd4) || (w_py >= c_vlim);

        w_rgb = 12'h000;
        if (vidon) begin
            if (w_in_spr) begin
                w_rgb = 12'hF00;
            end else if (w_border) begin
                w_rgb = 12'hFFF;
            end else begin
                w_rgb = 12'h00F;
            end
        end
    end

    always_ff @(posedge clk25) begin
        if (!rst_n) begin
            r_btn_s1            <= 5'b0;
            r_btn_s2            <= 5'b0;
            r_btn_c_prev        <= 1'b0;
            r_vs_prev           <= 1'b1;
            frame_tick          <= 1'b0;
            r_x                 <= c_x_init;
            r_y                 <= c_y_init;
            r_dx                <= 1'b1;
            r_dy                <= 1'b1;
            r_state             <= ST_RUN;
            {red, green, blue}  <= 12'h000;
            hsync_out           <= 1'b1;
            vsync_out           <= 1'b1;
        end else begin
            r_btn_s1     <= {btn_c, btn_right, btn_left, btn_down, btn_up};
            r_btn_s2     <= r_btn_s1;
            r_btn_c_prev <= r_btn_s2[4];
            r_vs_prev    <= vsync_in;
            frame_tick   <= r_vs_prev & ~vsync_in;

            // The update reads the current state, so a btn_c edge landing on
            // the tick cycle still lets this frame use the pre-toggle state.
            if (frame_tick && (r_state == ST_RUN)) begin
                r_x  <= w_x_upd[9:0];
                r_dx <= w_x_upd[10];
                r_y  <= w_y_upd[9:0];
                r_dy <= w_y_upd[10];
            end

            if (w_btn_c_rise) begin
                r_state <= (r_state == ST_RUN) ? ST_PAUSE : ST_RUN;
            end

            {red, green, blue} <= w_rgb;
            hsync_out          <= hsync_in;
            vsync_out          <= vsync_in;
        end
    end

endmodule
`default_nettype wire
